// File: rtl/stp_ctrl_pkg.sv
// ============================================================================
// stp_ctrl_pkg : shared types for the serial-to-parallel frame controller
// Rev 1.0
// ============================================================================
`default_nettype none

package stp_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      HOLD = 2'd2
   } stp_state_t;

   localparam int FRAME_LEN_DEFAULT = 48;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// sat_counter : saturating up-counter; clear with same-cycle increment gives 1
// Rev 1.0
// ============================================================================
`default_nettype none

module sat_counter #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         n_rst,
   input  logic         inc_i,
   input  logic         clr_i,
   output logic [W-1:0] count_o
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   always_comb begin
      count_d = count_q;
      if (clr_i) begin
         count_d = inc_i ? W'(1) : '0;
      end else if (inc_i && (count_q != '1)) begin
         count_d = count_q + W'(1);
      end
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/stp_frame_ctrl.sv
// ============================================================================
// stp_frame_ctrl : sequences the serial-to-parallel sample register feeding the FFT
// Rev 1.0
// ============================================================================
`default_nettype none

module stp_frame_ctrl
   import stp_ctrl_pkg::*;
#(
   parameter int FRAME_LEN = FRAME_LEN_DEFAULT,
   parameter int CNT_W     = 6,
   parameter int FID_W     = 16,
   parameter int DROP_W    = 8
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              enable,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              shift_strobe,
   output logic [CNT_W-1:0]  fill_count,
   output logic              frame_valid,
   input  logic              frame_ack,
   output logic [FID_W-1:0]  frame_id,
   output logic              overrun,
   input  logic              overrun_clr,
   output logic [DROP_W-1:0] drop_count
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_LEN - 1);

   stp_state_t       state_q, state_d;
   logic [CNT_W-1:0] fill_q, fill_d;
   logic [FID_W-1:0] fid_q, fid_d;
   logic             ovr_q, ovr_d;
   logic             fv_q;
   logic             drop;

   always_comb begin
      state_d      = state_q;
      fill_d       = fill_q;
      fid_d        = fid_q;
      in_ready     = 1'b0;
      shift_strobe = 1'b0;
      drop         = 1'b0;
      case (state_q)
         IDLE: begin
            fill_d = '0;
            drop   = in_valid & enable;
            if (enable) state_d = FILL;
         end
         FILL: begin
            in_ready = 1'b1;
            // Disabling discards the partial frame, so the strobe is withheld too.
            if (!enable) begin
               state_d = IDLE;
               fill_d  = '0;
            end else if (in_valid) begin
               shift_strobe = 1'b1;
               if (fill_q == LAST_IDX) begin
                  fill_d  = '0;
                  state_d = HOLD;
               end else begin
                  fill_d = fill_q + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            drop = in_valid;
            if (frame_ack) begin
               fid_d   = fid_q + FID_W'(1);
               state_d = enable ? FILL : IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
      ovr_d = drop ? 1'b1 : (overrun_clr ? 1'b0 : ovr_q);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q <= IDLE;
         fill_q  <= '0;
         fid_q   <= '0;
         ovr_q   <= 1'b0;
         fv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         fill_q  <= fill_d;
         fid_q   <= fid_d;
         ovr_q   <= ovr_d;
         fv_q    <= (state_d == HOLD);
      end
   end

   sat_counter #(
      .W (DROP_W)
   ) u_drop_cnt (
      .clk     (clk),
      .n_rst   (n_rst),
      .inc_i   (drop),
      .clr_i   (overrun_clr),
      .count_o (drop_count)
   );

   assign fill_count  = fill_q;
   assign frame_valid = fv_q;
   assign frame_id    = fid_q;
   assign overrun     = ovr_q;

endmodule

`default_nettype wire

// File: tb/tb_stp_frame_ctrl.sv
// ============================================================================
// tb_stp_frame_ctrl : directed, table-driven checks for stp_frame_ctrl
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_stp_frame_ctrl;

   localparam int FL = 48;

   logic        clk;
   logic        n_rst;
   logic        enable;
   logic        in_valid;
   logic        in_ready;
   logic        shift_strobe;
   logic [5:0]  fill_count;
   logic        frame_valid;
   logic        frame_ack;
   logic [15:0] frame_id;
   logic        overrun;
   logic        overrun_clr;
   logic [7:0]  drop_count;

   int n_checks;
   int n_errors;

   typedef struct {
      logic       en;
      logic       iv;
      logic       ack;
      logic       clr;
      logic       e_rdy;
      logic       e_stb;
      logic [5:0] e_fill;
      logic       e_fv;
      logic       chk_rdy;
   } vec_t;

   vec_t vecs[$];

   stp_frame_ctrl #(
      .FRAME_LEN (FL),
      .CNT_W     (6),
      .FID_W     (16),
      .DROP_W    (8)
   ) dut (
      .clk          (clk),
      .n_rst        (n_rst),
      .enable       (enable),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .shift_strobe (shift_strobe),
      .fill_count   (fill_count),
      .frame_valid  (frame_valid),
      .frame_ack    (frame_ack),
      .frame_id     (frame_id),
      .overrun      (overrun),
      .overrun_clr  (overrun_clr),
      .drop_count   (drop_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   function automatic vec_t mk(input logic en, input logic iv, input logic ack, input logic clr,
                               input logic rdy, input logic stb, input int fill, input logic fv);
      vec_t v;
      v.en = en; v.iv = iv; v.ack = ack; v.clr = clr;
      v.e_rdy = rdy; v.e_stb = stb; v.e_fill = 6'(fill); v.e_fv = fv; v.chk_rdy = 1'b1;
      return v;
   endfunction

   // Drive at the falling edge, check mid-low-phase, then advance through one rising edge.
   task automatic step(input vec_t v, input string tag);
      enable      = v.en;
      in_valid    = v.iv;
      frame_ack   = v.ack;
      overrun_clr = v.clr;
      #1;
      if (v.chk_rdy) chk({tag, ".in_ready"}, 32'(in_ready), 32'(v.e_rdy));
      chk({tag, ".shift_strobe"}, 32'(shift_strobe), 32'(v.e_stb));
      chk({tag, ".fill_count"},   32'(fill_count),   32'(v.e_fill));
      chk({tag, ".frame_valid"},  32'(frame_valid),  32'(v.e_fv));
      @(negedge clk);
   endtask

   task automatic check_regs(input string tag, input int id, input logic ov, input int dc);
      chk({tag, ".frame_id"},   32'(frame_id),   32'(id));
      chk({tag, ".overrun"},    32'(overrun),    32'(ov));
      chk({tag, ".drop_count"}, 32'(drop_count), 32'(dc));
   endtask

   // One IDLE->FILL cycle followed by a full frame of back-to-back accepts.
   task automatic fill_frame(input string tag);
      step(mk(1, 0, 0, 0, 0, 0, 0, 0), {tag, ".start"});
      for (int i = 0; i < FL; i++) step(mk(1, 1, 0, 0, 1, 1, i, 0), {tag, ".acc"});
   endtask

   initial begin
      vec_t v;
      n_checks = 0;
      n_errors = 0;
      n_rst = 1'b0; enable = 1'b0; in_valid = 1'b0; frame_ack = 1'b0; overrun_clr = 1'b0;

      // Reset values
      #1;
      chk("rst.in_ready", 32'(in_ready), 0);
      chk("rst.shift_strobe", 32'(shift_strobe), 0);
      chk("rst.fill_count", 32'(fill_count), 0);
      chk("rst.frame_valid", 32'(frame_valid), 0);
      check_regs("rst", 0, 0, 0);
      @(negedge clk);
      @(negedge clk);
      n_rst = 1'b1;

      // Frame 1: full back-to-back frame, 5 dropped samples in HOLD, then ack
      vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0));
      for (int i = 0; i < FL; i++) vecs.push_back(mk(1, 1, 0, 0, 1, 1, i, 0));
      for (int i = 0; i < 5; i++) vecs.push_back(mk(1, 1, 0, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 0, 1, 0, 0, 0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0));
      foreach (vecs[i]) step(vecs[i], $sformatf("tbl[%0d]", i));
      check_regs("f1", 1, 1, 5);

      // Gapped input: one sample every third cycle; already in FILL
      for (int k = 0; k < FL; k++) begin
         step(mk(1, 0, 0, 0, 1, 0, k, 0), "gap.idle");
         step(mk(1, 0, 0, 0, 1, 0, k, 0), "gap.idle");
         step(mk(1, 1, 0, 0, 1, 1, k, 0), "gap.acc");
      end
      step(mk(1, 0, 1, 0, 0, 0, 0, 1), "gap.ack");
      check_regs("gap", 2, 1, 5);

      // Abort after 20 accepts; in_ready is not judged on the abort cycle
      for (int i = 0; i < 20; i++) step(mk(1, 1, 0, 0, 1, 1, i, 0), "abort.acc");
      v = mk(0, 1, 0, 0, 1, 0, 20, 0);
      v.chk_rdy = 1'b0;
      step(v, "abort.cut");
      step(mk(0, 1, 0, 0, 0, 0, 0, 0), "abort.idle");
      check_regs("abort", 2, 1, 5);
      step(mk(1, 0, 0, 0, 0, 0, 0, 0), "reen.start");
      for (int i = 0; i < FL; i++) step(mk(1, 1, 0, 0, 1, 1, i, 0), "reen.acc");
      step(mk(0, 0, 1, 0, 0, 0, 0, 1), "reen.ack");
      step(mk(0, 0, 0, 0, 0, 0, 0, 0), "reen.idle");
      check_regs("reen", 3, 1, 5);

      // Saturating drop counter while a frame is held
      fill_frame("sat");
      for (int i = 0; i < 300; i++) step(mk(0, 1, 0, 0, 0, 0, 0, 1), "sat.drop");
      check_regs("sat", 3, 1, 255);
      step(mk(0, 1, 0, 1, 0, 0, 0, 1), "clr.drop");
      check_regs("clr_drop", 3, 1, 1);
      step(mk(0, 0, 0, 1, 0, 0, 0, 1), "clr.only");
      check_regs("clr_only", 3, 0, 0);

      // Asynchronous reset in HOLD
      n_rst = 1'b0;
      #1;
      chk("arst.in_ready", 32'(in_ready), 0);
      chk("arst.fill_count", 32'(fill_count), 0);
      chk("arst.frame_valid", 32'(frame_valid), 0);
      check_regs("arst", 0, 0, 0);
      @(negedge clk);
      n_rst = 1'b1;
      step(mk(0, 0, 1, 0, 0, 0, 0, 0), "post.ack");
      step(mk(0, 0, 1, 0, 0, 0, 0, 0), "post.ack");
      check_regs("post", 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire
